// File: rtl/trainer_stimulus_gen.sv
`default_nettype none
// ============================================================================
// Module   : trainer_stimulus_gen
// Brief    : Steps operands a/b through the 2-input truth table, either on a
//            debounced button press or automatically at a fixed period.
// Revision : 1.0
// ============================================================================
module trainer_stimulus_gen #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int AUTO_PERIOD     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step_btn,
   input  logic       auto_en,
   input  logic       hold,
   output logic       a,
   output logic       b,
   output logic [1:0] vec_idx,
   output logic       vec_strobe,
   output logic       sweep_done
);

   localparam int c_dcnt_w = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int c_pcnt_w = $clog2(AUTO_PERIOD);
   localparam logic [c_dcnt_w-1:0] c_dcnt_last = c_dcnt_w'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_pcnt_w-1:0] c_pcnt_last = c_pcnt_w'(AUTO_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_MANUAL = 2'd0,
      ST_AUTO   = 2'd1,
      ST_PAUSE  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic                r_s1;
   logic                r_s2;
   logic                r_db;
   logic                r_db_d;
   logic [c_dcnt_w-1:0] r_dcnt;
   logic [c_pcnt_w-1:0] r_pcnt;
   logic [c_pcnt_w-1:0] w_pcnt_next;
   logic                w_step;
   logic                w_advance;
   logic [1:0]          w_idx_next;

   // Synchronizer and debouncer: any return of s2 to the accepted level restarts the count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_db   <= 1'b0;
         r_db_d <= 1'b0;
         r_dcnt <= '0;
      end else begin
         r_s1   <= step_btn;
         r_s2   <= r_s1;
         r_db_d <= r_db;
         if (r_s2 == r_db) begin
            r_dcnt <= '0;
         end else if (r_dcnt == c_dcnt_last) begin
            r_db   <= r_s2;
            r_dcnt <= '0;
         end else begin
            r_dcnt <= r_dcnt + 1'b1;
         end
      end
   end

   assign w_step     = r_db & ~r_db_d;
   assign w_idx_next = vec_idx + 2'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_MANUAL;
         r_pcnt  <= '0;
      end else begin
         r_state <= w_next_state;
         r_pcnt  <= w_pcnt_next;
      end
   end

   // A cycle with hold sampled high freezes pcnt, so each such cycle delays the advance by one
   always_comb begin
      w_next_state = r_state;
      w_pcnt_next  = r_pcnt;
      w_advance    = 1'b0;
      case (r_state)
         ST_MANUAL: begin
            if (auto_en) begin
               w_next_state = hold ? ST_PAUSE : ST_AUTO;
               w_pcnt_next  = '0;
            end else if (w_step) begin
               w_advance = 1'b1;
            end
         end
         ST_AUTO, ST_PAUSE: begin
            if (!auto_en) begin
               w_next_state = ST_MANUAL;
            end else if (hold) begin
               w_next_state = ST_PAUSE;
            end else begin
               w_next_state = ST_AUTO;
               if (r_pcnt == c_pcnt_last) begin
                  w_advance   = 1'b1;
                  w_pcnt_next = '0;
               end else begin
                  w_pcnt_next = r_pcnt + 1'b1;
               end
            end
         end
         default: begin
            w_next_state = ST_MANUAL;
            w_pcnt_next  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_idx    <= 2'd0;
         a          <= 1'b0;
         b          <= 1'b0;
         vec_strobe <= 1'b0;
         sweep_done <= 1'b0;
      end else begin
         vec_strobe <= w_advance;
         sweep_done <= w_advance && (vec_idx == 2'd3);
         if (w_advance) begin
            vec_idx <= w_idx_next;
            a       <= w_idx_next[1];
            b       <= w_idx_next[0];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_trainer_stimulus_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_trainer_stimulus_gen
// Brief    : Scoreboard bench; stimulus queues expected advances, a monitor checks strobes.
// Revision : 1.0
// ============================================================================
module tb_trainer_stimulus_gen;

   localparam int c_deb = 4;
   localparam int c_per = 8;

   logic       clk;
   logic       rst;
   logic       step_btn;
   logic       auto_en;
   logic       hold;
   logic       a;
   logic       b;
   logic [1:0] vec_idx;
   logic       vec_strobe;
   logic       sweep_done;

   typedef struct {
      int         edge_n;
      logic [1:0] idx;
      logic       sweep;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_x;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         m;
   logic [1:0] m_idx;

   trainer_stimulus_gen #(
      .DEBOUNCE_CYCLES(c_deb),
      .AUTO_PERIOD    (c_per)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .step_btn  (step_btn),
      .auto_en   (auto_en),
      .hold      (hold),
      .a         (a),
      .b         (b),
      .vec_idx   (vec_idx),
      .vec_strobe(vec_strobe),
      .sweep_done(sweep_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: the next advance lands at edge e
   task automatic push_adv(input int e);
      exp_t x;
      x.sweep  = (m_idx == 2'd3);
      m_idx    = m_idx + 2'd1;
      x.edge_n = e;
      x.idx    = m_idx;
      sb.push_back(x);
   endtask

   task automatic goto(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic press(input int hold_cyc);
      push_adv(cyc + 1 + c_deb + 2);
      step_btn = 1'b1;
      repeat (hold_cyc) @(negedge clk);
      step_btn = 1'b0;
      repeat (c_deb + 6) @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_idx"}, 32'(vec_idx), 32'd0);
      chk({tag, "_a"}, 32'(a), 32'd0);
      chk({tag, "_b"}, 32'(b), 32'd0);
      chk({tag, "_strobe"}, 32'(vec_strobe), 32'd0);
      chk({tag, "_sweep"}, 32'(sweep_done), 32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (vec_strobe) begin
            if (sb.size() == 0) begin
               chk("unexpected_strobe", 32'(vec_idx), 32'hffff_ffff);
            end else begin
               mon_x = sb.pop_front();
               chk("strobe_edge", 32'(cyc), 32'(mon_x.edge_n));
               chk("vec_idx", 32'(vec_idx), 32'(mon_x.idx));
               chk("a", 32'(a), 32'(mon_x.idx[1]));
               chk("b", 32'(b), 32'(mon_x.idx[0]));
               chk("sweep_done", 32'(sweep_done), 32'(mon_x.sweep));
            end
         end else if (sweep_done) begin
            chk("sweep_no_strobe", 32'(sweep_done), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      step_btn = 1'b0;
      auto_en  = 1'b0;
      hold     = 1'b0;
      m_idx    = 2'd0;
      @(negedge clk);
      #2;
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);

      // Clean press, then a bouncing press, then four clean presses
      press(10);
      step_btn = 1'b1; @(negedge clk);
      step_btn = 1'b0; @(negedge clk);
      step_btn = 1'b1; @(negedge clk);
      step_btn = 1'b0; @(negedge clk);
      press(10);
      repeat (4) press(10);

      // Asynchronous reset mid-sweep
      chk("pre_reset_idx", 32'(vec_idx), 32'd2);
      #2;
      rst = 1'b1;
      #1;
      chk_zero("async_reset");
      m_idx = 2'd0;
      @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);

      // Auto mode with a button press and a 5-cycle hold
      auto_en = 1'b1;
      m = cyc + 1;
      for (int i = 1; i <= 4; i++) push_adv(m + c_per * i);
      goto(m + 2);
      step_btn = 1'b1;
      goto(m + 12);
      step_btn = 1'b0;
      goto(m + 34);
      hold = 1'b1;
      goto(m + 39);
      hold = 1'b0;
      push_adv(m + 45);

      // auto_en falls exactly on the terminal-count edge
      goto(m + 52);
      auto_en = 1'b0;
      repeat (20) @(negedge clk);
      chk("idx_after_mode", 32'(vec_idx), 32'(m_idx));
      press(10);

      // Reset while the button is held: exactly one step after release
      step_btn = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_zero("held_reset");
      m_idx = 2'd0;
      @(negedge clk);
      rst = 1'b0;
      push_adv(cyc + 1 + c_deb + 2);
      repeat (12) @(negedge clk);
      step_btn = 1'b0;
      repeat (30) @(negedge clk);

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      chk("final_idx", 32'(vec_idx), 32'(m_idx));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
